// File: rtl/sync_filter.sv
// Multi-channel CDC synchronizer with per-channel stability filter and edge pulses.
// Each channel: STAGES-deep flop chain, then an optional FILTER_LEN-cycle debounce.
`timescale 1ns/1ps

module sync_filter_lane #(
    parameter int   N   = 3,
    parameter int   CW  = 2,
    parameter logic RST = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_raw,
    output logic o_out
);
    logic [CW-1:0] r_cnt;
    logic          r_out;

    // Counter only advances while raw disagrees with the output, so it tops out at N-1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
            r_out <= RST;
        end else if (i_raw == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(N - 1)) begin
            r_out <= i_raw;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_out = r_out;
endmodule

module sync_filter #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 3,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);
    logic [STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]             w_raw;
    logic [WIDTH-1:0]             w_filt;
    logic [WIDTH-1:0]             r_prev;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_sync <= {STAGES{RESET_VAL}};
        else        r_sync <= {r_sync[STAGES-2:0], async_in};
    end

    assign w_raw = r_sync[STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign w_filt = w_raw;
        end else begin : g_filter
            localparam int CW = $clog2(FILTER_LEN + 1);
            for (genvar g = 0; g < WIDTH; g++) begin : g_lane
                sync_filter_lane #(
                    .N   (FILTER_LEN),
                    .CW  (CW),
                    .RST (RESET_VAL[g])
                ) u_lane (
                    .clk   (clk),
                    .n_rst (n_rst),
                    .i_raw (w_raw[g]),
                    .o_out (w_filt[g])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_prev <= RESET_VAL;
        else        r_prev <= w_filt;
    end

    // Pulses decode registered state only, so reset release cannot create an edge.
    assign sync_out = w_filt;
    assign rise     = w_filt & ~r_prev;
    assign fall     = ~w_filt & r_prev;
    assign any_edge = |(rise | fall);
endmodule
